// File: rtl/number_game_ctrl.sv
// number_game_ctrl: single-clock round sequencer for the number game.
// Start a round with key 3. The value latched from `random` is shown for
// SHOW_CYCLES cycles and then blanked. The player enters a guess on `sw` and
// submits it with key 1. The result pattern stays on `led` for RESULT_CYCLES
// cycles. Key 2 aborts the round.
//
// Ports:
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   key[3:1]   raw active-low buttons (3 start, 2 abort, 1 submit)
//   sw         player guess (quasi-static, sampled only while judging)
//   random     free-running value from rand10
//   score      rounds won, saturating at 99
//   number     current target value
//   num_blank  1 = the display shows blank instead of `number`
//   led        result pattern (3FF hit, 001 miss)
//   busy       1 whenever a round is in progress
//
// Optional feature: define NUMBER_GAME_TIMEOUT_EN to bound the guess window
// to GUESS_CYCLES cycles. An expired window is judged as a miss.
module number_game_ctrl #(
   parameter int unsigned SHOW_CYCLES   = 50_000_000,
   parameter int unsigned GUESS_CYCLES  = 500_000_000,
   parameter int unsigned RESULT_CYCLES = 50_000_000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:1] key,
   input  logic [9:0] sw,
   input  logic [9:0] random,
   output logic [6:0] score,
   output logic [9:0] number,
   output logic       num_blank,
   output logic [9:0] led,
   output logic       busy
);

   // Reject illegal parameter values at elaboration
   if (SHOW_CYCLES < 1) begin : g_chk_show
      $error("SHOW_CYCLES must be >= 1");
   end
   if (GUESS_CYCLES < 1) begin : g_chk_guess
      $error("GUESS_CYCLES must be >= 1");
   end
   if (RESULT_CYCLES < 1) begin : g_chk_result
      $error("RESULT_CYCLES must be >= 1");
   end

   localparam int unsigned MAX_SR = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
`ifdef NUMBER_GAME_TIMEOUT_EN
   localparam int unsigned MAX_CYC = (GUESS_CYCLES > MAX_SR) ? GUESS_CYCLES : MAX_SR;
`else
   localparam int unsigned MAX_CYC = MAX_SR;
`endif
   // The counter only ever holds values up to MAX_CYC-1
   localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESULT_LOAD = CNT_W'(RESULT_CYCLES - 1);
`ifdef NUMBER_GAME_TIMEOUT_EN
   localparam logic [CNT_W-1:0] GUESS_LOAD  = CNT_W'(GUESS_CYCLES - 1);
`endif
   localparam logic [6:0]       SCORE_MAX   = 7'd99;
   localparam logic [9:0]       LED_HIT     = 10'h3FF;
   localparam logic [9:0]       LED_MISS    = 10'h001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW,
      S_GUESS,
      S_JUDGE,
      S_RESULT
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       score_q, score_d;
   logic [9:0]       number_q, number_d;
   logic             num_blank_q, num_blank_d;
   logic [9:0]       led_q, led_d;
   logic             busy_q, busy_d;
   logic [3:1]       sync1_q, sync2_q, prev_q;
   logic             ev_start, ev_abort, ev_submit;
   logic             hit;
`ifdef NUMBER_GAME_TIMEOUT_EN
   logic             force_miss_q, force_miss_d;
`endif

   // Key synchroniser plus falling-edge detector; a held key yields one event
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
         prev_q  <= 3'b111;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign ev_start  = prev_q[3] & ~sync2_q[3];
   assign ev_abort  = prev_q[2] & ~sync2_q[2];
   assign ev_submit = prev_q[1] & ~sync2_q[1];

`ifdef NUMBER_GAME_TIMEOUT_EN
   assign hit = (sw == number_q) && !force_miss_q;
`else
   assign hit = (sw == number_q);
`endif

   // State and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         score_q     <= '0;
         number_q    <= '0;
         num_blank_q <= 1'b0;
         led_q       <= '0;
         busy_q      <= 1'b0;
`ifdef NUMBER_GAME_TIMEOUT_EN
         force_miss_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         score_q     <= score_d;
         number_q    <= number_d;
         num_blank_q <= num_blank_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
`ifdef NUMBER_GAME_TIMEOUT_EN
         force_miss_q <= force_miss_d;
`endif
      end
   end

   // Next-state and output logic; abort wins over every other event
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      score_d     = score_q;
      number_d    = number_q;
      num_blank_d = num_blank_q;
      led_d       = led_q;
`ifdef NUMBER_GAME_TIMEOUT_EN
      force_miss_d = force_miss_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (ev_start) begin
               number_d    = random;
               num_blank_d = 1'b0;
               led_d       = '0;
               cnt_d       = SHOW_LOAD;
               state_d     = S_SHOW;
            end
         end
         S_SHOW: begin
            if (ev_abort) begin
               led_d       = '0;
               num_blank_d = 1'b0;
               state_d     = S_IDLE;
            end else if (cnt_q == '0) begin
               num_blank_d = 1'b1;
               state_d     = S_GUESS;
`ifdef NUMBER_GAME_TIMEOUT_EN
               cnt_d        = GUESS_LOAD;
               force_miss_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GUESS: begin
            if (ev_abort) begin
               led_d       = '0;
               num_blank_d = 1'b0;
               state_d     = S_IDLE;
            end else if (ev_submit) begin
               state_d = S_JUDGE;
`ifdef NUMBER_GAME_TIMEOUT_EN
            end else if (cnt_q == '0) begin
               force_miss_d = 1'b1;
               state_d      = S_JUDGE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
`endif
            end
         end
         S_JUDGE: begin
            // A pending abort pulse is dropped here; the judge always completes
            if (hit) begin
               led_d = LED_HIT;
               if (score_q < SCORE_MAX) begin
                  score_d = score_q + 7'd1;
               end
            end else begin
               led_d = LED_MISS;
            end
            num_blank_d = 1'b0;
            cnt_d       = RESULT_LOAD;
            state_d     = S_RESULT;
         end
         S_RESULT: begin
            if (ev_abort) begin
               led_d       = '0;
               num_blank_d = 1'b0;
               state_d     = S_IDLE;
            end else if (cnt_q == '0) begin
               led_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign score     = score_q;
   assign number    = number_q;
   assign num_blank = num_blank_q;
   assign led       = led_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_number_game_ctrl.sv
// Bench for number_game_ctrl: directed rounds from the test plan plus
// randomized rounds against a round-level model (expected score, target and
// LED pattern derived from the game rules and the key-to-event latency).
module tb_number_game_ctrl;

   localparam int unsigned SHOW_C   = 4;
   localparam int unsigned GUESS_C  = 5;
   localparam int unsigned RESULT_C = 3;
`ifdef NUMBER_GAME_TIMEOUT_EN
   localparam int MAX_GD = 1;
`else
   localparam int MAX_GD = 5;
`endif

   logic       clock;
   logic       resetn;
   logic [3:1] key;
   logic [9:0] sw;
   logic [9:0] random;
   logic [6:0] score;
   logic [9:0] number;
   logic       num_blank;
   logic [9:0] led;
   logic       busy;

   int n_cmp;
   int n_err;
   int exp_score;
   logic [9:0] exp_num;

   number_game_ctrl #(
      .SHOW_CYCLES  (SHOW_C),
      .GUESS_CYCLES (GUESS_C),
      .RESULT_CYCLES(RESULT_C)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .key      (key),
      .sw       (sw),
      .random   (random),
      .score    (score),
      .number   (number),
      .num_blank(num_blank),
      .led      (led),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_led"},   32'(led), 32'd0);
      chk({tag, "_blank"}, 32'(num_blank), 32'd0);
      chk({tag, "_score"}, 32'(score), 32'(exp_score));
      chk({tag, "_num"},   32'(number), 32'(exp_num));
   endtask

   // Called at a negedge: hold keys m low, return 3 negedges later, which is
   // the first cycle after the resulting event took effect.
   task automatic press(input logic [3:1] m);
      key = ~m;
      repeat (3) @(negedge clock);
      key = 3'b111;
   endtask

   // abort_at: 0 none, 1 SHOW, 2 GUESS, 3 RESULT, 4 async reset in RESULT
   task automatic play_round(input logic [9:0] rv, input logic [9:0] guess,
                             input int abort_at, input int gd, input bit start_in_show);
      logic [9:0] exp_led;
      bit hit;
      random = rv;
      press(3'b100);
      random = 10'($urandom);
      exp_num = rv;
      chk("show_num",   32'(number), 32'(rv));
      chk("show_blank", 32'(num_blank), 32'd0);
      chk("show_busy",  32'(busy), 32'd1);
      chk("show_led",   32'(led), 32'd0);
      if (abort_at == 1) begin
         press(3'b011);
         check_idle("abort_show");
         return;
      end
      if (start_in_show) begin
         @(negedge clock);
         press(3'b100);
      end else begin
         repeat (SHOW_C - 1) begin
            @(negedge clock);
            chk("show_blank", 32'(num_blank), 32'd0);
         end
         @(negedge clock);
      end
      chk("guess_blank", 32'(num_blank), 32'd1);
      chk("guess_num",   32'(number), 32'(rv));
      chk("guess_busy",  32'(busy), 32'd1);
      sw = guess;
      repeat (gd) @(negedge clock);
      if (abort_at == 2) begin
         press(3'b011);
         check_idle("abort_guess");
         return;
      end
      key[1] = 1'b0;
      @(negedge clock);
      @(negedge clock);
      if (abort_at == 3) key[2] = 1'b0;
      @(negedge clock);
      key = (abort_at == 3) ? 3'b101 : 3'b111;
      chk("judge_score", 32'(score), 32'(exp_score));
      chk("judge_led",   32'(led), 32'd0);
      chk("judge_blank", 32'(num_blank), 32'd1);
      hit = (guess == rv);
      if (hit && exp_score < 99) exp_score++;
      exp_led = hit ? 10'h3FF : 10'h001;
      @(negedge clock);
      key = 3'b111;
      chk("result_led",   32'(led), 32'(exp_led));
      chk("result_score", 32'(score), 32'(exp_score));
      chk("result_blank", 32'(num_blank), 32'd0);
      chk("result_num",   32'(number), 32'(rv));
      if (abort_at == 3) begin
         @(negedge clock);
         check_idle("abort_result");
         return;
      end
      if (abort_at == 4) begin
         #2 resetn = 1'b0;
         #1;
         exp_score = 0;
         exp_num = '0;
         check_idle("async_rst");
         @(negedge clock);
         resetn = 1'b1;
         @(negedge clock);
         return;
      end
      repeat (RESULT_C - 1) begin
         @(negedge clock);
         chk("result_led", 32'(led), 32'(exp_led));
      end
      @(negedge clock);
      check_idle("round_end");
   endtask

`ifdef NUMBER_GAME_TIMEOUT_EN
   task automatic timeout_round(input logic [9:0] rv);
      random = rv;
      press(3'b100);
      exp_num = rv;
      repeat (SHOW_C) @(negedge clock);
      chk("to_blank", 32'(num_blank), 32'd1);
      sw = rv;
      repeat (GUESS_C) @(negedge clock);
      chk("to_judge_led",   32'(led), 32'd0);
      chk("to_judge_blank", 32'(num_blank), 32'd1);
      @(negedge clock);
      chk("to_led",   32'(led), 32'h001);
      chk("to_score", 32'(score), 32'(exp_score));
      repeat (RESULT_C) @(negedge clock);
      check_idle("to_end");
   endtask
`endif

   initial begin
      logic [9:0] rv;
      logic [9:0] g;
      int ab;
      n_cmp = 0;
      n_err = 0;
      exp_score = 0;
      exp_num = '0;
      resetn = 1'b0;
      key = 3'b111;
      sw = '0;
      random = '0;
      #1;
      check_idle("reset");
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check_idle("post_reset");

      // Directed rounds: hit, miss, aborts with simultaneous keys, ignored start
      play_round(10'd517, 10'd517, 0, 0, 0);
      chk("first_win", 32'(score), 32'd1);
      play_round(10'd517, 10'd516, 0, 0, 0);
      play_round(10'd300, 10'd300, 1, 0, 0);
      play_round(10'd301, 10'd301, 2, 1, 0);
      play_round(10'd302, 10'd302, 0, 0, 1);
      play_round(10'd303, 10'd303, 3, 0, 0);

      // Randomized rounds
      for (int i = 0; i < 40; i++) begin
         rv = 10'($urandom);
         g  = ($urandom_range(0, 1) == 0) ? rv : 10'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         play_round(rv, g, ab, int'($urandom_range(0, MAX_GD)), bit'($urandom_range(0, 1)));
      end

      // Saturation at 99
      while (exp_score < 99) begin
         rv = 10'($urandom);
         play_round(rv, rv, 0, 0, 0);
      end
      rv = 10'($urandom);
      play_round(rv, rv, 0, 0, 0);
      chk("sat_score", 32'(score), 32'd99);

      // Asynchronous reset in RESULT
      rv = 10'($urandom);
      play_round(rv, rv, 4, 0, 0);
      chk("after_rst_score", 32'(score), 32'd0);

`ifdef NUMBER_GAME_TIMEOUT_EN
      timeout_round(10'd77);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
